dram_nibble_responder: RTL and testbench

- Synthesizable, clocked responder for the multiplexed 4-bit DRAM port driven by the R15229844 delay controller.
- Emulates a 64K x 4 (4464-class) DRAM on the controller's own clock, so an FPGA rebuild needs no external DRAM.
- Decodes nDRAM_RAS / nDRAM_CAS / nDRAM_WE. Supports row latch, page-mode column accesses, early write, late write (read-modify-write), RAS-only refresh and CAS-before-RAS (CBR) refresh.
- Stores data in an external synchronous block RAM with 1-cycle read latency.

---
 rtl/dram_resp_pkg.sv | 17 +
 rtl/strobe_sync.sv | 36 +++
 rtl/dram_nibble_responder.sv | 197 +++++++++++++++++++
 tb/tb_dram_nibble_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_resp_pkg.sv
// Shared types and default widths for the nibble-wide DRAM responder.
package dram_resp_pkg;

  localparam int ROW_W_DEF = 8;
  localparam int DW_DEF    = 4;
  localparam int REF_W     = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROW     = 3'd1,
    RD_WAIT = 3'd2,
    RD_HOLD = 3'd3,
    WRITE   = 3'd4,
    CBR     = 3'd5
  } state_t;

endpackage

// File: rtl/strobe_sync.sv
// Synchronizes one active-low strobe and flags its edges on the synchronized level.
// Latency: level after SYNC_STAGES cycles; fall/rise valid in the cycle the new level appears.
// Backpressure: none; free-running sampler.
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic pin,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Strobes idle high, so reset fills the chain with the inactive level.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign fall  = prev & ~level;
  assign rise  = ~prev & level;

endmodule

// File: rtl/dram_nibble_responder.sv
// Emulates a 64K x 4 page-mode DRAM on the controller clock, backed by a 1-cycle synchronous block RAM.
// Latency: write strobe SYNC_STAGES cycles after the sampled CAS/WE edge; read data SYNC_STAGES+2 cycles after CAS.
// Backpressure: none; the controller paces every access through its RAS/CAS timing.
module dram_nibble_responder
  import dram_resp_pkg::*;
#(
  parameter int ROW_W       = ROW_W_DEF,
  parameter int DW          = DW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_IN,
  input  logic               nRESET,
  input  logic               nDRAM_RAS,
  input  logic               nDRAM_CAS,
  input  logic               nDRAM_WE,
  input  logic [ROW_W-1:0]   DRAM_A,
  input  logic [DW-1:0]      DRAM_D_wr,
  output logic [DW-1:0]      DRAM_D_rd,
  output logic               DRAM_D_oe,
  output logic [2*ROW_W-1:0] MEM_ADDR,
  output logic [DW-1:0]      MEM_WDATA,
  output logic               MEM_WE,
  input  logic [DW-1:0]      MEM_RDATA,
  output logic [REF_W-1:0]   REFRESH_CNT,
  output logic               PROTO_ERR
);

  logic ras_lvl, ras_fall, ras_rise;
  logic cas_lvl, cas_fall, cas_rise;
  logic we_lvl, we_fall, unused_we_rise;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ras_sync (
    .core_clk (CLK_IN),
    .arst_n   (nRESET),
    .pin      (nDRAM_RAS),
    .level    (ras_lvl),
    .fall     (ras_fall),
    .rise     (ras_rise)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cas_sync (
    .core_clk (CLK_IN),
    .arst_n   (nRESET),
    .pin      (nDRAM_CAS),
    .level    (cas_lvl),
    .fall     (cas_fall),
    .rise     (cas_rise)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_we_sync (
    .core_clk (CLK_IN),
    .arst_n   (nRESET),
    .pin      (nDRAM_WE),
    .level    (we_lvl),
    .fall     (we_fall),
    .rise     (unused_we_rise)
  );

  // Address and data ride chains of the same depth so they line up with the strobe edges.
  logic [ROW_W-1:0] a_pipe [SYNC_STAGES];
  logic [DW-1:0]    d_pipe [SYNC_STAGES];

  always_ff @(posedge CLK_IN or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_pipe[i] <= '0;
        d_pipe[i] <= '0;
      end
    end else begin
      a_pipe[0] <= DRAM_A;
      d_pipe[0] <= DRAM_D_wr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_pipe[i] <= a_pipe[i-1];
        d_pipe[i] <= d_pipe[i-1];
      end
    end
  end

  logic [ROW_W-1:0] a_s;
  logic [DW-1:0]    d_s;
  assign a_s = a_pipe[SYNC_STAGES-1];
  assign d_s = d_pipe[SYNC_STAGES-1];

  state_t           state;
  logic [ROW_W-1:0] row_q;
  logic             cas_seen;
  logic             col_pend;
  logic             rd_pend;
  logic             cbr_armed;
  logic             col_go;
  logic             err_evt;
  logic             refresh_done;

  // A RAS+CAS fall together latches the column one cycle later if CAS is still low.
  assign col_go       = cas_fall | (col_pend & ~cas_lvl);
  assign err_evt      = (we_fall & ras_lvl) | (cas_fall & ((state == RD_WAIT) | (state == WRITE)));
  assign refresh_done = ((state == ROW) & ~cas_seen) | ((state == CBR) & cbr_armed);

  always_ff @(posedge CLK_IN or negedge nRESET) begin
    if (!nRESET) begin
      state       <= IDLE;
      row_q       <= '0;
      cas_seen    <= 1'b0;
      col_pend    <= 1'b0;
      rd_pend     <= 1'b0;
      cbr_armed   <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_WDATA   <= '0;
      MEM_WE      <= 1'b0;
      DRAM_D_rd   <= '0;
      DRAM_D_oe   <= 1'b0;
      REFRESH_CNT <= '0;
      PROTO_ERR   <= 1'b0;
    end else begin
      MEM_WE <= 1'b0;
      if (err_evt) begin
        PROTO_ERR <= 1'b1;
      end

      if (ras_rise) begin
        if (refresh_done) begin
          REFRESH_CNT <= REFRESH_CNT + REF_W'(1);
        end
        state     <= IDLE;
        DRAM_D_oe <= 1'b0;
        rd_pend   <= 1'b0;
        col_pend  <= 1'b0;
        cbr_armed <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ras_fall && (cas_lvl || cas_fall)) begin
              row_q    <= a_s;
              cas_seen <= 1'b0;
              col_pend <= cas_fall;
              state    <= ROW;
            end else if (cas_fall && ras_lvl) begin
              cbr_armed <= 1'b0;
              state     <= CBR;
            end
          end
          ROW: begin
            col_pend <= 1'b0;
            if (col_go) begin
              MEM_ADDR <= {row_q, a_s};
              cas_seen <= 1'b1;
              if (!we_lvl) begin
                MEM_WE    <= 1'b1;
                MEM_WDATA <= d_s;
                state     <= WRITE;
              end else begin
                rd_pend <= 1'b0;
                state   <= RD_WAIT;
              end
            end
          end
          // First cycle lets the RAM register the address; the second captures its output.
          RD_WAIT: begin
            if (!rd_pend) begin
              rd_pend <= 1'b1;
            end else begin
              rd_pend   <= 1'b0;
              DRAM_D_rd <= MEM_RDATA;
              DRAM_D_oe <= 1'b1;
              state     <= RD_HOLD;
            end
          end
          RD_HOLD: begin
            if (cas_rise) begin
              DRAM_D_oe <= 1'b0;
              state     <= ROW;
            end else if (we_fall) begin
              DRAM_D_oe <= 1'b0;
              MEM_WE    <= 1'b1;
              MEM_WDATA <= d_s;
              state     <= WRITE;
            end
          end
          WRITE: begin
            if (cas_rise) begin
              state <= ROW;
            end
          end
          CBR: begin
            if (ras_fall && !cas_lvl) begin
              cbr_armed <= 1'b1;
            end else if (cas_rise && !cbr_armed) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dram_nibble_responder.sv
// Randomized DRAM-protocol bench with a transaction-level memory model and a per-cycle output checker.
module tb_dram_nibble_responder;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [7:0]  a = '0;
  logic [3:0]  dd = '0;
  logic [3:0]  d_rd;
  logic        d_oe;
  logic [15:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_rdata = '0;
  logic [7:0]  ref_cnt;
  logic        proto_err;

  always #5 clk = ~clk;

  dram_nibble_responder #(.ROW_W(8), .DW(4), .SYNC_STAGES(SS)) dut (
    .CLK_IN      (clk),
    .nRESET      (nrst),
    .nDRAM_RAS   (ras),
    .nDRAM_CAS   (cas),
    .nDRAM_WE    (we),
    .DRAM_A      (a),
    .DRAM_D_wr   (dd),
    .DRAM_D_rd   (d_rd),
    .DRAM_D_oe   (d_oe),
    .MEM_ADDR    (mem_addr),
    .MEM_WDATA   (mem_wdata),
    .MEM_WE      (mem_we),
    .MEM_RDATA   (mem_rdata),
    .REFRESH_CNT (ref_cnt),
    .PROTO_ERR   (proto_err)
  );

  // Block RAM the DUT drives; separate from the model below.
  logic [3:0] ram [65536];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: what the memory must hold and which events must appear.
  logic [3:0]  model_mem [65536];
  logic [19:0] exp_wr [$];
  logic [3:0]  exp_rd [$];
  logic [7:0]  model_ref = '0;
  logic        model_err = 1'b0;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of write strobes and read-data launches against the model queues.
  logic oe_q = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (mem_we) begin
          check("write_expected", 32'(exp_wr.size() != 0), 1);
          if (exp_wr.size() != 0) check("mem_write", {mem_addr, mem_wdata}, exp_wr.pop_front());
        end
        if (d_oe && !oe_q) begin
          check("read_expected", 32'(exp_rd.size() != 0), 1);
          if (exp_rd.size() != 0) check("read_data", d_rd, exp_rd.pop_front());
        end
      end
      oe_q = d_oe;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state();
    check("refresh_cnt", ref_cnt, model_ref);
    check("proto_err", proto_err, model_err);
    check("oe_idle", d_oe, 0);
    check("writes_drained", exp_wr.size(), 0);
    check("reads_drained", exp_rd.size(), 0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  task automatic row_open(input logic [7:0] r);
    a = r; tick(3); ras = 1'b0; tick(4);
  endtask

  task automatic row_close();
    ras = 1'b1; tick(4);
  endtask

  task automatic col_read(input logic [7:0] r, input logic [7:0] c);
    a = c; we = 1'b1; tick(3);
    exp_rd.push_back(model_mem[{r, c}]);
    cas = 1'b0; tick(6);
    cas = 1'b1; tick(4);
  endtask

  task automatic col_write(input logic [7:0] r, input logic [7:0] c, input logic [3:0] d);
    a = c; dd = d; we = 1'b0; tick(3);
    exp_wr.push_back({r, c, d});
    model_mem[{r, c}] = d;
    cas = 1'b0; tick(5);
    cas = 1'b1; we = 1'b1; tick(4);
  endtask

  task automatic col_rmw(input logic [7:0] r, input logic [7:0] c, input logic [3:0] d);
    a = c; we = 1'b1; tick(3);
    exp_rd.push_back(model_mem[{r, c}]);
    cas = 1'b0; tick(6);
    dd = d; tick(3);
    exp_wr.push_back({r, c, d});
    model_mem[{r, c}] = d;
    we = 1'b0; tick(4);
    check("rmw_oe_dropped", d_oe, 0);
    cas = 1'b1; we = 1'b1; tick(4);
  endtask

  task automatic ras_refresh();
    a = 8'($urandom); tick(3);
    ras = 1'b0; tick(4);
    ras = 1'b1; tick(4);
    model_ref = model_ref + 8'd1;
  endtask

  task automatic cbr();
    cas = 1'b0; tick(4);
    ras = 1'b0; tick(4);
    ras = 1'b1; tick(4);
    cas = 1'b1; tick(4);
    model_ref = model_ref + 8'd1;
  endtask

  task automatic rand_op();
    int kind, n, t;
    logic [7:0] r, c;
    logic [3:0] d;
    kind = $urandom_range(0, 9);
    if (kind == 0) ras_refresh();
    else if (kind == 1) cbr();
    else begin
      r = 8'($urandom_range(0, 3));
      row_open(r);
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        c = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
        d = 4'($urandom);
        t = $urandom_range(0, 2);
        case (t)
          0: col_read(r, c);
          1: col_write(r, c, d);
          default: col_rmw(r, c, d);
        endcase
      end
      row_close();
    end
    check_state();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = '0;
      model_mem[i] = '0;
    end

    tick(3);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_oe", d_oe, 0);
    check("rst_rd", d_rd, 0);
    check("rst_refresh", ref_cnt, 0);
    check("rst_proto_err", proto_err, 0);
    nrst = 1'b1;
    tick(3);
    chk_en = 1'b1;

    // 256 RAS-only refreshes wrap the counter.
    for (int i = 0; i < 255; i++) ras_refresh();
    check("refresh_255", ref_cnt, 8'd255);
    ras_refresh();
    check("refresh_wrap", ref_cnt, 8'd0);
    check_state();

    // Early write then read-back with latency pinned.
    row_open(8'h12);
    col_write(8'h12, 8'h34, 4'hA);
    a = 8'h34; we = 1'b1; tick(3);
    exp_rd.push_back(model_mem[16'h1234]);
    cas = 1'b0;
    @(posedge clk);
    repeat (SS + 1) @(posedge clk);
    #1 check("rd_latency_early", d_oe, 0);
    @(posedge clk);
    #1 check("rd_latency_oe", d_oe, 1);
    check("rd_data_literal", d_rd, 4'hA);
    tick(3);
    cas = 1'b1; tick(4);
    row_close();
    check_state();

    // Page mode across one row, including the top column.
    row_open(8'h05);
    col_write(8'h05, 8'h00, 4'h3);
    col_write(8'h05, 8'h01, 4'h7);
    col_write(8'h05, 8'hFF, 4'h9);
    col_read(8'h05, 8'hFF);
    col_read(8'h05, 8'h00);
    row_close();
    check_state();

    // Late write: read returns 0x3, then 0xC lands at 0x0203.
    row_open(8'h02);
    col_write(8'h02, 8'h03, 4'h3);
    col_rmw(8'h02, 8'h03, 4'hC);
    col_read(8'h02, 8'h03);
    row_close();
    check_state();
    check("rmw_model_pin", model_mem[16'h0203], 4'hC);

    // RAS and CAS falling together; the column follows one cycle later.
    row_open(8'h07);
    col_write(8'h07, 8'h09, 4'hB);
    row_close();
    a = 8'h07; we = 1'b1; tick(3);
    ras = 1'b0; cas = 1'b0; tick(1);
    a = 8'h09;
    exp_rd.push_back(model_mem[16'h0709]);
    tick(6);
    cas = 1'b1; tick(4);
    row_close();
    check_state();

    cbr();
    check("cbr_count", ref_cnt, 8'd1);
    check_state();

    for (int i = 0; i < 60; i++) rand_op();

    // WE pulse while RAS is high is a sticky violation.
    we = 1'b0; tick(4);
    we = 1'b1; tick(4);
    model_err = 1'b1;
    check_state();
    for (int i = 0; i < 4; i++) rand_op();

    // Reset asserted while the write strobe is high.
    row_open(8'h40);
    a = 8'h41; dd = 4'h5; we = 1'b0; tick(3);
    chk_en = 1'b0;
    cas = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1 if (mem_we) seen = 1'b1;
    end
    check("rst_write_seen", 32'(seen), 1);
    nrst = 1'b0; ras = 1'b1; cas = 1'b1; we = 1'b1;
    #1;
    check("rst_async_we", mem_we, 0);
    check("rst_async_err", proto_err, 0);
    check("rst_async_cnt", ref_cnt, 0);
    tick(3);
    nrst = 1'b1;
    model_ref = '0;
    model_err = 1'b0;
    tick(3);
    oe_q = 1'b0;
    chk_en = 1'b1;
    row_open(8'h40);
    col_read(8'h40, 8'h41);
    row_close();
    ras_refresh();
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
